abstract_cmd_engine: RTL and testbench

- Debug-module stage directly upstream of the core register-file bridge.
- Accepts RISC-V debug "Access Register" abstract commands and owns the data0 message register.
- Sequences reg_read/reg_write toward the bridge and captures returned read data into data0.
- Maintains busy and cmderr for the DM register front-end.

---
 rtl/abstract_cmd_engine.sv | 200 ++++++++++++++++++++
 tb/tb_abstract_cmd_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/abstract_cmd_engine.sv
// abstract_cmd_engine
// Debug-module stage in front of the core register-file bridge. It accepts
// "Access Register" abstract commands, owns data0, sequences one reg_write or
// an RD_LAT-cycle reg_read toward the bridge, and keeps busy/cmderr for the
// DM register front-end.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cmd_valid/wdata    command register write strobe and command word
//   data0_we/wdata     DM write access to data0
//   cmderr_w1c         write-1-to-clear mask for cmderr
//   halted             core halted status
//   data0, cmd_q       data0 register, latched (post-incremented) command
//   busy, cmderr       command in progress, sticky error code
//   cmd_done           one-cycle completion pulse
//   reg_read/write     bridge requests (never both high)
//   reg_addr/wdata     GPR index and write data (mirrors data0)
//   reg_rdata          bridge read data
module abstract_cmd_engine #(
  parameter int unsigned RD_LAT   = 2,
  parameter logic [15:0] GPR_BASE = 16'h1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_wdata,
  input  logic        data0_we,
  input  logic [31:0] data0_wdata,
  input  logic [2:0]  cmderr_w1c,
  input  logic        halted,
  output logic [31:0] data0,
  output logic [31:0] cmd_q,
  output logic        busy,
  output logic [2:0]  cmderr,
  output logic        cmd_done,
  output logic        reg_read,
  output logic        reg_write,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata
);

  localparam int unsigned CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned GPR_CNT = 32;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BUSY    = 3'd1;
  localparam logic [2:0] ERR_NOTSUP  = 3'd2;
  localparam logic [2:0] ERR_HALTRES = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_next;
  logic [31:0]      data0_next;
  logic [31:0]      cmd_q_next;
  logic [2:0]       cmderr_next;
  logic             busy_next;
  logic             cmd_done_next;
  logic             reg_read_next;
  logic             reg_write_next;
  logic [4:0]       reg_addr_next;

  // Command word fields
  logic [7:0]  cmdtype;
  logic [2:0]  aarsize;
  logic        transfer;
  logic        is_write;
  logic [15:0] regno;
  logic [15:0] gpr_ofs;
  logic        gpr_ok;

  assign cmdtype  = cmd_wdata[31:24];
  assign aarsize  = cmd_wdata[22:20];
  assign transfer = cmd_wdata[17];
  assign is_write = cmd_wdata[16];
  assign regno    = cmd_wdata[15:0];

  // Offset from the GPR window base; a single compare covers both range ends
  assign gpr_ofs = regno - GPR_BASE;
  assign gpr_ok  = (gpr_ofs < 16'(GPR_CNT));

  // Write data is always the current data0 register
  assign reg_wdata = data0;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      data0     <= '0;
      cmd_q     <= '0;
      cmderr    <= '0;
      busy      <= 1'b0;
      cmd_done  <= 1'b0;
      reg_read  <= 1'b0;
      reg_write <= 1'b0;
      reg_addr  <= '0;
    end else begin
      state     <= state_next;
      rd_cnt    <= rd_cnt_next;
      data0     <= data0_next;
      cmd_q     <= cmd_q_next;
      cmderr    <= cmderr_next;
      busy      <= busy_next;
      cmd_done  <= cmd_done_next;
      reg_read  <= reg_read_next;
      reg_write <= reg_write_next;
      reg_addr  <= reg_addr_next;
    end
  end

  // Next-state, datapath and next-output logic
  always_comb begin
    state_next     = state;
    rd_cnt_next    = rd_cnt;
    data0_next     = data0;
    cmd_q_next     = cmd_q;
    cmderr_next    = cmderr & ~cmderr_w1c;
    busy_next      = 1'b0;
    cmd_done_next  = 1'b0;
    reg_read_next  = 1'b0;
    reg_write_next = 1'b0;
    reg_addr_next  = '0;

    case (state)
      IDLE: begin
        if (data0_we) begin
          data0_next = data0_wdata;
        end
        if (cmd_valid && (cmderr == ERR_NONE)) begin
          if (cmdtype != 8'd0) begin
            cmderr_next = ERR_NOTSUP;
          end else if (transfer && (aarsize != 3'd2)) begin
            cmderr_next = ERR_NOTSUP;
          end else if (transfer && !gpr_ok) begin
            cmderr_next = ERR_NOTSUP;
          end else if (!halted) begin
            cmderr_next = ERR_HALTRES;
          end else begin
            cmd_q_next  = cmd_wdata;
            rd_cnt_next = '0;
            if (!transfer) begin
              state_next = DONE;
            end else if (is_write) begin
              state_next = WRITE;
            end else begin
              state_next = READ;
            end
          end
        end
      end
      WRITE: begin
        state_next = DONE;
      end
      READ: begin
        if (rd_cnt == CNT_W'(RD_LAT - 1)) begin
          state_next = CAPTURE;
        end else begin
          rd_cnt_next = rd_cnt + CNT_W'(1);
        end
      end
      CAPTURE: begin
        data0_next = reg_rdata;
        state_next = DONE;
      end
      DONE: begin
        if (cmd_q[19]) begin
          cmd_q_next[15:0] = cmd_q[15:0] + 16'd1;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // DM accesses while busy are dropped and flag a busy error; this set
    // overrides any same-cycle write-1-to-clear
    if ((state != IDLE) && (cmd_valid || data0_we) && (cmderr == ERR_NONE)) begin
      cmderr_next = ERR_BUSY;
    end

    // Outputs are registered so they line up with the state being entered
    busy_next      = (state_next != IDLE);
    cmd_done_next  = (state_next == DONE);
    reg_write_next = (state_next == WRITE);
    reg_read_next  = (state_next == READ);
    if ((state_next == WRITE) || (state_next == READ)) begin
      reg_addr_next = cmd_q_next[4:0];
    end
  end

endmodule

// File: tb/tb_abstract_cmd_engine.sv
// Directed self-checking bench for abstract_cmd_engine (RD_LAT = 2).
module tb_abstract_cmd_engine;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [31:0] cmd_wdata;
  logic        data0_we;
  logic [31:0] data0_wdata;
  logic [2:0]  cmderr_w1c;
  logic        halted;
  logic [31:0] data0;
  logic [31:0] cmd_q;
  logic        busy;
  logic [2:0]  cmderr;
  logic        cmd_done;
  logic        reg_read;
  logic        reg_write;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_cmdq = 32'h0;

  abstract_cmd_engine #(.RD_LAT(2), .GPR_BASE(16'h1000)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_wdata   (cmd_wdata),
    .data0_we    (data0_we),
    .data0_wdata (data0_wdata),
    .cmderr_w1c  (cmderr_w1c),
    .halted      (halted),
    .data0       (data0),
    .cmd_q       (cmd_q),
    .busy        (busy),
    .cmderr      (cmderr),
    .cmd_done    (cmd_done),
    .reg_read    (reg_read),
    .reg_write   (reg_write),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd;
    logic        hlt;
    logic [31:0] d0;
    logic [31:0] rdata;
    logic [2:0]  exp_err;
    logic [15:0] exp_busy;
    logic [15:0] exp_done;
    logic [15:0] exp_wr;
    logic [15:0] exp_rd;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data0;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Clear cmderr, preload data0, set halted and the bridge read data
  task automatic prep(input logic [31:0] d0, input logic hlt, input logic [31:0] rdata);
    @(posedge clk); #1;
    cmderr_w1c  = 3'b111;
    data0_we    = 1'b1;
    data0_wdata = d0;
    halted      = hlt;
    reg_rdata   = rdata;
    @(posedge clk); #1;
    cmderr_w1c  = 3'b000;
    data0_we    = 1'b0;
  endtask

  // Drive a command strobe for one cycle (cycle N); caller observes after
  task automatic issue(input logic [31:0] cmd);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_wdata = cmd;
  endtask

  // Record cycles N+1..N+12 as bit masks; count bridge-protocol violations
  task automatic observe(input logic [4:0] ea, input logic [31:0] ew,
                         output logic [15:0] bm, output logic [15:0] dm,
                         output logic [15:0] wm, output logic [15:0] rm,
                         output int bad);
    bm = '0; dm = '0; wm = '0; rm = '0; bad = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        cmd_valid = 1'b0;
        data0_we  = 1'b0;
      end
      bm[k] = busy;
      dm[k] = cmd_done;
      wm[k] = reg_write;
      rm[k] = reg_read;
      if (reg_write && ((reg_addr !== ea) || (reg_wdata !== ew))) bad++;
      if (reg_read && (reg_addr !== ea)) bad++;
      if (reg_read && reg_write) bad++;
    end
  endtask

  function automatic logic [31:0] next_cmdq(input logic [31:0] cur, input logic [31:0] cmd,
                                            input logic [2:0] err);
    logic [31:0] r;
    r = cur;
    if (err == 3'd0) begin
      r = cmd;
      if (cmd[19]) r[15:0] = cmd[15:0] + 16'd1;
    end
    return r;
  endfunction

  vec_t vecs[17];
  logic [15:0] bm, dm, wm, rm;
  int bad;
  int done_k;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_wdata = '0; data0_we = 1'b0;
    data0_wdata = '0; cmderr_w1c = '0; halted = 1'b0; reg_rdata = '0;

    //          cmd           h  d0            rdata         err busy     done     wr       rd       addr  data0
    vecs[0]  = '{32'h0023_1005, 1, 32'hDEADBEEF, 32'h0,        0, 16'h0006, 16'h0004, 16'h0002, 16'h0000, 5'd5,  32'hDEADBEEF};
    vecs[1]  = '{32'h0022_1007, 1, 32'h00000000, 32'h12345678, 0, 16'h001E, 16'h0010, 16'h0000, 16'h0006, 5'd7,  32'h12345678};
    vecs[2]  = '{32'h0020_0000, 1, 32'hA5A5A5A5, 32'h0,        0, 16'h0002, 16'h0002, 16'h0000, 16'h0000, 5'd0,  32'hA5A5A5A5};
    vecs[3]  = '{32'h0122_1007, 1, 32'h11111111, 32'h0,        2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'd0,  32'h11111111};
    vecs[4]  = '{32'h0032_1007, 1, 32'h22222222, 32'h0,        2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'd0,  32'h22222222};
    vecs[5]  = '{32'h0022_1020, 1, 32'h33333333, 32'h0,        2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'd0,  32'h33333333};
    vecs[6]  = '{32'h0022_0FFF, 1, 32'h44444444, 32'h0,        2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'd0,  32'h44444444};
    vecs[7]  = '{32'h0022_1007, 0, 32'h55555555, 32'h0,        4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'd0,  32'h55555555};
    vecs[8]  = '{32'h0122_1007, 0, 32'h66666666, 32'h0,        2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'd0,  32'h66666666};
    vecs[9]  = '{32'h0030_0000, 1, 32'h77777777, 32'h0,        0, 16'h0002, 16'h0002, 16'h0000, 16'h0000, 5'd0,  32'h77777777};
    vecs[10] = '{32'h0023_101F, 1, 32'h0BADF00D, 32'h0,        0, 16'h0006, 16'h0004, 16'h0002, 16'h0000, 5'd31, 32'h0BADF00D};
    vecs[11] = '{32'h0022_1000, 1, 32'h01010101, 32'hCAFEF00D, 0, 16'h001E, 16'h0010, 16'h0000, 16'h0006, 5'd0,  32'hCAFEF00D};
    vecs[12] = '{32'h002A_101F, 1, 32'h02020202, 32'h55AA55AA, 0, 16'h001E, 16'h0010, 16'h0000, 16'h0006, 5'd31, 32'h55AA55AA};
    vecs[13] = '{32'h002A_1020, 1, 32'h88888888, 32'h0,        2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'd0,  32'h88888888};
    vecs[14] = '{32'h0008_FFFF, 1, 32'h99999999, 32'h0,        0, 16'h0002, 16'h0002, 16'h0000, 16'h0000, 5'd0,  32'h99999999};
    vecs[15] = '{32'h0022_001F, 1, 32'hABABABAB, 32'h0,        2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'd0,  32'hABABABAB};
    vecs[16] = '{32'h0023_1005, 0, 32'hCDCDCDCD, 32'h0,        4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'd0,  32'hCDCDCDCD};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   32'(busy),      32'h0);
    check("rst_cmderr", 32'(cmderr),    32'h0);
    check("rst_data0",  data0,          32'h0);
    check("rst_cmdq",   cmd_q,          32'h0);
    check("rst_rw",     32'({reg_read, reg_write, cmd_done}), 32'h0);
    rst = 1'b0;

    // Table-driven commands
    for (int i = 0; i < 17; i++) begin
      prep(vecs[i].d0, vecs[i].hlt, vecs[i].rdata);
      issue(vecs[i].cmd);
      observe(vecs[i].exp_addr, vecs[i].d0, bm, dm, wm, rm, bad);
      model_cmdq = next_cmdq(model_cmdq, vecs[i].cmd, vecs[i].exp_err);
      check($sformatf("v%0d_cmderr", i), 32'(cmderr), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_busy", i),   32'(bm), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d_done", i),   32'(dm), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_wr", i),     32'(wm), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d_rd", i),     32'(rm), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_bridge", i), 32'(bad), 32'h0);
      check($sformatf("v%0d_data0", i),  data0, vecs[i].exp_data0);
      check($sformatf("v%0d_cmdq", i),   cmd_q, model_cmdq);
    end

    // Sticky error: not halted -> 4, further commands ignored, w1c clears
    prep(32'h0, 1'b0, 32'h0);
    issue(32'h0022_1007);
    observe(5'd7, 32'h0, bm, dm, wm, rm, bad);
    check("halt_err4", 32'(cmderr), 32'h4);
    check("halt_nobusy", 32'(bm), 32'h0);
    halted = 1'b1;
    issue(32'h0023_1005);
    observe(5'd5, 32'h0, bm, dm, wm, rm, bad);
    check("sticky_ignored_busy", 32'(bm), 32'h0);
    check("sticky_err_held", 32'(cmderr), 32'h4);
    check("sticky_cmdq", cmd_q, model_cmdq);
    @(posedge clk); #1; cmderr_w1c = 3'b111;
    @(posedge clk); #1; cmderr_w1c = 3'b000;
    check("w1c_clear", 32'(cmderr), 32'h0);
    reg_rdata = 32'h0BB0_1234;
    issue(32'h0022_1007);
    observe(5'd7, 32'h0, bm, dm, wm, rm, bad);
    model_cmdq = 32'h0022_1007;
    check("halted_read_busy", 32'(bm), 32'h001E);
    check("halted_read_data0", data0, 32'h0BB0_1234);

    // Accesses while busy: busy error set beats same-cycle clear; read completes
    prep(32'hF0F0F0F0, 1'b1, 32'h0F1E2D3C);
    issue(32'h0022_1007);
    @(posedge clk); #1;
    cmd_wdata   = 32'h0023_1005;
    data0_we    = 1'b1;
    data0_wdata = 32'hBAD0BAD0;
    cmderr_w1c  = 3'b111;
    done_k = 0;
    wm = '0;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        check("busy_err_set_wins", 32'(cmderr), 32'h1);
        cmd_valid = 1'b0; data0_we = 1'b0; cmderr_w1c = 3'b000;
      end
      if (cmd_done && done_k == 0) done_k = k;
      wm[k] = reg_write;
    end
    check("busy_done_at", 32'(done_k), 32'd4);
    check("busy_no_write", 32'(wm), 32'h0);
    check("busy_data0", data0, 32'h0F1E2D3C);
    check("busy_cmdq", cmd_q, 32'h0022_1007);
    check("busy_err_sticky", 32'(cmderr), 32'h1);

    // data0 write together with an accepted write command drives new value
    prep(32'h00000001, 1'b1, 32'h0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_wdata = 32'h0023_1009;
    data0_we = 1'b1; data0_wdata = 32'h600DCAFE;
    observe(5'd9, 32'h600DCAFE, bm, dm, wm, rm, bad);
    check("same_cyc_wr", 32'(wm), 32'h0002);
    check("same_cyc_bridge", 32'(bad), 32'h0);
    check("same_cyc_data0", data0, 32'h600DCAFE);

    // Reset in the second READ cycle aborts the command
    prep(32'hC0C0C0C0, 1'b1, 32'h11112222);
    issue(32'h0022_1007);
    @(posedge clk); #1;
    check("rst_mid_rd1", 32'(reg_read), 32'h1);
    @(posedge clk); #1;
    check("rst_mid_rd2", 32'(reg_read), 32'h1);
    check("rst_mid_err1", 32'(cmderr), 32'h1);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_read", 32'(reg_read), 32'h0);
    check("rst_mid_data0", data0, 32'h0);
    check("rst_mid_cmderr", 32'(cmderr), 32'h0);
    check("rst_mid_cmdq", cmd_q, 32'h0);
    @(posedge clk); #1;
    check("rst_mid_after", 32'({busy, reg_read, cmd_done}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
